// File: rtl/ws2812_pkg.sv
`default_nettype none
// ============================================================================
// ws2812_pkg : shared WS2812 RZ line definitions (decoder states, 50 MHz timing)
// Revision   : 1.0
// ============================================================================
package ws2812_pkg;

   typedef enum logic [1:0] {
      SYNC = 2'd0,
      IDLE = 2'd1,
      HIGH = 2'd2,
      LOW  = 2'd3
   } rz_state_t;

   // Nominal transmitter timing at 50 MHz, in clock cycles
   localparam int T0H       = 16;
   localparam int T1H       = 46;
   localparam int TBIT      = 63;
   localparam int TRESET_TX = 15000;

   localparam int WORD_BITS = 24;
   localparam bit MSB_FIRST = 1'b1;

endpackage
`default_nettype wire

// File: rtl/rz_decoder_sync_edge.sv
`default_nettype none
// ============================================================================
// rz_sync_edge : input synchronizer with rise/fall single-cycle pulses
// Revision     : 1.0
// ============================================================================
module rz_sync_edge
   import ws2812_pkg::*;
#(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic rz_in,
   output logic rz_s,
   output logic rise,
   output logic fall
);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   prev_q, prev_d;

   always_comb begin
      sync_d = {sync_q[SYNC_STAGES-2:0], rz_in};
      prev_d = sync_q[SYNC_STAGES-1];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= sync_d;
         prev_q <= prev_d;
      end
   end

   assign rz_s = sync_q[SYNC_STAGES-1];
   assign rise = rz_s & ~prev_q;
   assign fall = ~rz_s & prev_q;

endmodule
`default_nettype wire

// File: rtl/rz_decoder.sv
`default_nettype none
// ============================================================================
// rz_decoder : WS2812 RZ receiver - pulse-width bit decode, 24-bit word assembly
// Revision   : 1.0
// ============================================================================
module rz_decoder
   import ws2812_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int HIGH_MIN    = 4,
   parameter int BIT_THRESH  = 31,
   parameter int HIGH_MAX    = 75,
   parameter int RESET_CYC   = 2500,
   parameter int CNT_W       = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rz_in,
   output logic [23:0] rgb_out,
   output logic        rgb_valid,
   output logic [15:0] pixel_idx,
   output logic        frame_end,
   output logic        bit_err,
   output logic        busy
);

   // Counter is cleared on the edge cycle, so a width of w cycles reads w-1
   // on the cycle that detects the closing edge.
   localparam logic [CNT_W-1:0] CNT_MAX    = '1;
   localparam logic [CNT_W-1:0] GLITCH_LIM = CNT_W'(HIGH_MIN - 1);
   localparam logic [CNT_W-1:0] ZERO_LIM   = CNT_W'(BIT_THRESH);
   localparam logic [CNT_W-1:0] STUCK_LIM  = CNT_W'(HIGH_MAX - 1);
   localparam logic [CNT_W-1:0] RESET_LIM  = CNT_W'(RESET_CYC - 2);

   logic rz_s, rise, fall;

   rz_sync_edge #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_sync_edge (
      .clk   (clk),
      .rst   (rst),
      .rz_in (rz_in),
      .rz_s  (rz_s),
      .rise  (rise),
      .fall  (fall)
   );

   rz_state_t        state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [4:0]       bit_cnt_q, bit_cnt_d;
   logic [23:0]      shift_q, shift_d;
   logic             word_done_q, word_done_d;
   logic [15:0]      word_cnt_q, word_cnt_d;
   logic [23:0]      rgb_out_q, rgb_out_d;
   logic             rgb_valid_q, rgb_valid_d;
   logic [15:0]      pixel_idx_q, pixel_idx_d;
   logic             frame_end_q, frame_end_d;
   logic             bit_err_q, bit_err_d;
   logic             busy_q, busy_d;
   logic             new_bit;

   always_comb begin
      state_d     = state_q;
      cnt_d       = (rise || fall) ? '0 : ((cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1);
      bit_cnt_d   = bit_cnt_q;
      shift_d     = shift_q;
      word_done_d = 1'b0;
      word_cnt_d  = word_cnt_q;
      rgb_out_d   = rgb_out_q;
      rgb_valid_d = 1'b0;
      pixel_idx_d = pixel_idx_q;
      frame_end_d = 1'b0;
      bit_err_d   = 1'b0;
      busy_d      = busy_q;
      new_bit     = (cnt_q >= ZERO_LIM);

      if (word_done_q) begin
         rgb_out_d   = shift_q;
         rgb_valid_d = 1'b1;
         pixel_idx_d = word_cnt_q;
         word_cnt_d  = (word_cnt_q == 16'hFFFF) ? word_cnt_q : word_cnt_q + 16'd1;
      end

      case (state_q)
         SYNC: begin
            if (!rz_s && !fall && (cnt_q >= RESET_LIM))
               state_d = IDLE;
         end
         IDLE: begin
            if (rise) begin
               state_d = HIGH;
               busy_d  = 1'b1;
            end
         end
         HIGH: begin
            if ((fall && (cnt_q < GLITCH_LIM)) || (!fall && (cnt_q >= STUCK_LIM))) begin
               bit_err_d  = 1'b1;
               state_d    = SYNC;
               busy_d     = 1'b0;
               bit_cnt_d  = '0;
               word_cnt_d = '0;
            end else if (fall) begin
               shift_d = MSB_FIRST ? {shift_q[22:0], new_bit} : {new_bit, shift_q[23:1]};
               state_d = LOW;
               if (bit_cnt_q == 5'(WORD_BITS - 1)) begin
                  bit_cnt_d   = '0;
                  word_done_d = 1'b1;
               end else begin
                  bit_cnt_d = bit_cnt_q + 5'd1;
               end
            end
         end
         LOW: begin
            if (rise) begin
               state_d = HIGH;
            end else if (cnt_q >= RESET_LIM) begin
               frame_end_d = 1'b1;
               bit_err_d   = (bit_cnt_q != '0);
               bit_cnt_d   = '0;
               pixel_idx_d = '0;
               word_cnt_d  = '0;
               busy_d      = 1'b0;
               state_d     = IDLE;
            end
         end
         default: state_d = SYNC;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= SYNC;
         cnt_q       <= '0;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         word_done_q <= 1'b0;
         word_cnt_q  <= '0;
         rgb_out_q   <= '0;
         rgb_valid_q <= 1'b0;
         pixel_idx_q <= '0;
         frame_end_q <= 1'b0;
         bit_err_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         word_done_q <= word_done_d;
         word_cnt_q  <= word_cnt_d;
         rgb_out_q   <= rgb_out_d;
         rgb_valid_q <= rgb_valid_d;
         pixel_idx_q <= pixel_idx_d;
         frame_end_q <= frame_end_d;
         bit_err_q   <= bit_err_d;
         busy_q      <= busy_d;
      end
   end

   assign rgb_out   = rgb_out_q;
   assign rgb_valid = rgb_valid_q;
   assign pixel_idx = pixel_idx_q;
   assign frame_end = frame_end_q;
   assign bit_err   = bit_err_q;
   assign busy      = busy_q;

endmodule
`default_nettype wire
